mem: RTL and testbench
======================

Name: mem

Overview:
- Memory-access stage of the 5-stage RV32I pipeline.
- Sits between the ex_mem and mem_wb pipeline registers.
- Passes ALU results through unchanged. Executes loads and stores byte-serially over the single 8-bit RAM port.
- Raises stall_req while an access is in flight; pipeline control freezes pc/if_id/id_ex/ex_mem and bubbles mem_wb while stall_req=1.

Parameters:
ADDR_W, 32, width of mem_a_o and addr_i.

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
opcode_i  in  7  opcode from ex_mem (`OP_LOAD, `OP_STORE, others = pass-through)
func3_i  in  3  LB/LH/LW/LBU/LHU or SB/SH/SW selector
addr_i  in  ADDR_W  effective address computed by ex
sdata_i  in  32  store data (rs2 value)
wd_i  in  5  destination register
wreg_i  in  1  register-write enable
wdata_i  in  32  ALU result
mem_din_i  in  8  RAM read data; valid the cycle after the address is presented
mem_dout_o  out  8  RAM write byte
mem_a_o  out  ADDR_W  RAM byte address
mem_wr_o  out  1  1 = write, 0 = read
stall_req_o  out  1  request pipeline freeze
wd_o  out  5  to mem_wb
wreg_o  out  1  to mem_wb
wdata_o  out  32  to mem_wb

Behaviour:
- Reset (asynchronous, immediate, also mid-access):
  - State IDLE, byte counter 0, load buffer 0.
  - mem_wr_o=0, mem_a_o=0, mem_dout_o=0, stall_req_o=0.
  - wd_o=0, wreg_o=0, wdata_o=0.
  - An interrupted store leaves already-written bytes in RAM; this is not rolled back.
- Size N from func3: byte=1, half=2, word=4. Little-endian; byte k at addr_i+k, mod 2^ADDR_W (wraps at top of memory). No alignment check.
- FSM states: IDLE, LOAD, STORE, DONE. Counter cnt is 3 bits.
- IDLE:
  - Non-memory opcode: outputs combinationally follow wd_i/wreg_i/wdata_i; 0 extra latency; stall_req_o=0; mem_wr_o=0.
  - Load (cycle t0): mem_a_o=addr_i, stall_req_o=1, go to LOAD with cnt=1.
  - Store (cycle t0): mem_a_o=addr_i, mem_dout_o=sdata_i[7:0], mem_wr_o=1, stall_req_o=1. N=1 goes to DONE; otherwise go to STORE with cnt=1.
- LOAD, cycles t0+1 .. t0+N:
  - Capture mem_din_i into buffer byte cnt-1.
  - While cnt<N, present addr_i+cnt.
  - When cnt==N, go to DONE.
  - stall_req_o=1 throughout.
- STORE, cycles t0+1 .. t0+N-1:
  - mem_a_o=addr_i+cnt, mem_dout_o=sdata_i byte cnt, mem_wr_o=1, stall_req_o=1.
  - After byte N-1, go to DONE.
- DONE (one cycle):
  - stall_req_o=0, mem_wr_o=0.
  - Load: wdata_o = buffer sign-extended (LB/LH) or zero-extended (LBU/LHU); wd_o/wreg_o follow inputs.
  - Store: wreg_o=0.
  - Next state is IDLE. ex_mem advances at the end of this cycle, so the op is never re-issued.
- Outside DONE, while stall_req_o=1: wreg_o=0, wdata_o=0 (bubble to mem_wb).
- Latency: load N+2 cycles (stall N+1); store N+1 cycles (stall N).
- Back-to-back memory ops: the second op starts in the IDLE cycle after DONE.
- A load with wd_i=0 still performs the access; register x0 discards the write.
- Unknown func3 on a load/store: treat as word, fire $display error.
- mem_a_o/mem_dout_o are don't-care when no access is in progress; drive 0.

Decomposition:
- Shared defines.v gets `OP_LOAD, `OP_STORE, `FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW, `RstEnable, `ZeroWord, `RegBus, `RegAddrBus, and the FSM state encodings `MEM_IDLE/LOAD/STORE/DONE.
- One combinational sub-module, mem_load_ext: (func3, 32-bit buffer) -> extended 32-bit word.

Test Plan:
- addi pass-through, wd_i=5, wdata_i=0x1234 -> same cycle wd_o=5, wreg_o=1, wdata_o=0x1234, stall_req_o=0, mem_wr_o=0.
- LW addr 0x100, RAM[0x100..0x103]=0x78,0x56,0x34,0x12:
  - mem_a_o sequence 0x100..0x103.
  - stall_req_o high 5 cycles.
  - DONE cycle: wdata_o=0x12345678, wreg_o=1.
- LB vs LBU at byte 0x80:
  - LB -> wdata_o=0xFFFFFF80.
  - LBU -> 0x00000080.
  - LH of 0x8001 -> 0xFFFF8001.
- SH sdata_i=0xAABBCCDD, addr 0x200 -> writes 0xDD@0x200, 0xCC@0x201, mem_wr_o high 2 cycles, stall 2 cycles, wreg_o=0 in DONE.
- SW at 0xFFFFFFFE -> bytes written to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 (wrap).
- rst pulse in second byte of LW -> same-cycle mem_wr_o=0, stall_req_o=0, all outputs 0. After release, the IDLE state restarts the held op from byte 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants, the FSM state type and the access-size helper for the
// memory-access stage.
package mem_pkg;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;

   localparam logic        RST_ENABLE = 1'b1;
   localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

   typedef enum logic [1:0] {
      MEM_IDLE  = 2'd0,
      MEM_LOAD  = 2'd1,
      MEM_STORE = 2'd2,
      MEM_DONE  = 2'd3
   } mem_state_t;

   // Bytes moved by one access; unknown encodings are treated as a word.
   function automatic logic [2:0] access_size(input logic [2:0] func3);
      case (func3)
         FUNCT3_LB, FUNCT3_LBU: access_size = 3'd1;
         FUNCT3_LH, FUNCT3_LHU: access_size = 3'd2;
         default:               access_size = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_if.sv
// Bundle of ex_mem inputs, mem_wb outputs and the byte-wide RAM port.
interface mem_if #(
   parameter int ADDR_W = 32
);
   logic [6:0]        opcode_i;
   logic [2:0]        func3_i;
   logic [ADDR_W-1:0] addr_i;
   logic [31:0]       sdata_i;
   logic [4:0]        wd_i;
   logic              wreg_i;
   logic [31:0]       wdata_i;
   logic [7:0]        mem_din_i;
   logic [7:0]        mem_dout_o;
   logic [ADDR_W-1:0] mem_a_o;
   logic              mem_wr_o;
   logic              stall_req_o;
   logic [4:0]        wd_o;
   logic              wreg_o;
   logic [31:0]       wdata_o;

   modport slave (
      input  opcode_i, func3_i, addr_i, sdata_i, wd_i, wreg_i, wdata_i, mem_din_i,
      output mem_dout_o, mem_a_o, mem_wr_o, stall_req_o, wd_o, wreg_o, wdata_o
   );

   modport master (
      output opcode_i, func3_i, addr_i, sdata_i, wd_i, wreg_i, wdata_i, mem_din_i,
      input  mem_dout_o, mem_a_o, mem_wr_o, stall_req_o, wd_o, wreg_o, wdata_o
   );
endinterface

// File: rtl/mem_load_ext.sv
// Sign/zero extension of the assembled load buffer according to func3.
module mem_load_ext
   import mem_pkg::*;
(
   input  logic [2:0]  i_func3,
   input  logic [31:0] i_buf,
   output logic [31:0] o_word
);

   always_comb begin
      o_word = i_buf;
      case (i_func3)
         FUNCT3_LB:  o_word = {{24{i_buf[7]}}, i_buf[7:0]};
         FUNCT3_LH:  o_word = {{16{i_buf[15]}}, i_buf[15:0]};
         FUNCT3_LBU: o_word = {24'h0, i_buf[7:0]};
         FUNCT3_LHU: o_word = {16'h0, i_buf[15:0]};
         default:    o_word = i_buf;
      endcase
   end

endmodule

// File: rtl/mem.sv
// RV32I memory-access stage: ALU pass-through plus byte-serial loads/stores
// over an 8-bit RAM port, stalling the pipeline while an access is in flight.
module mem
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input logic   clk,
   input logic   rst,
   mem_if.slave  bus
);

   mem_state_t        r_state, w_state_next;
   logic [2:0]        r_cnt, w_cnt_next;
   logic [31:0]       r_buf, w_buf_next;
   logic [31:0]       w_ext;
   logic              w_is_load, w_is_store;
   logic [2:0]        w_size;
   logic [ADDR_W-1:0] w_addr_k;
   logic [7:0]        w_sbyte;
   logic [1:0]        w_ld_idx;

   assign w_is_load  = (bus.opcode_i == OP_LOAD);
   assign w_is_store = (bus.opcode_i == OP_STORE);
   assign w_size     = access_size(bus.func3_i);
   // Address arithmetic wraps naturally at the top of memory.
   assign w_addr_k   = bus.addr_i + ADDR_W'(r_cnt);
   assign w_sbyte    = bus.sdata_i[{r_cnt[1:0], 3'b000} +: 8];
   assign w_ld_idx   = r_cnt[1:0] - 2'd1;

   mem_load_ext u_load_ext (
      .i_func3 (bus.func3_i),
      .i_buf   (r_buf),
      .o_word  (w_ext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         r_state <= MEM_IDLE;
         r_cnt   <= 3'd0;
         r_buf   <= ZERO_WORD;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_buf   <= w_buf_next;
      end
   end

   // ex_mem is frozen while stalled, so the op fields are read live each cycle.
   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt;
      w_buf_next      = r_buf;
      bus.mem_a_o     = '0;
      bus.mem_dout_o  = 8'h00;
      bus.mem_wr_o    = 1'b0;
      bus.stall_req_o = 1'b0;
      bus.wd_o        = 5'd0;
      bus.wreg_o      = 1'b0;
      bus.wdata_o     = ZERO_WORD;

      if (rst != RST_ENABLE) begin
         case (r_state)
            MEM_IDLE: begin
               if (w_is_load) begin
                  bus.mem_a_o     = bus.addr_i;
                  bus.stall_req_o = 1'b1;
                  w_buf_next      = ZERO_WORD;
                  w_cnt_next      = 3'd1;
                  w_state_next    = MEM_LOAD;
               end else if (w_is_store) begin
                  bus.mem_a_o     = bus.addr_i;
                  bus.mem_dout_o  = bus.sdata_i[7:0];
                  bus.mem_wr_o    = 1'b1;
                  bus.stall_req_o = 1'b1;
                  if (w_size == 3'd1) begin
                     w_cnt_next   = 3'd0;
                     w_state_next = MEM_DONE;
                  end else begin
                     w_cnt_next   = 3'd1;
                     w_state_next = MEM_STORE;
                  end
               end else begin
                  bus.wd_o    = bus.wd_i;
                  bus.wreg_o  = bus.wreg_i;
                  bus.wdata_o = bus.wdata_i;
               end
            end
            MEM_LOAD: begin
               bus.stall_req_o = 1'b1;
               // RAM data now belongs to the address presented last cycle.
               w_buf_next[{w_ld_idx, 3'b000} +: 8] = bus.mem_din_i;
               if (r_cnt < w_size) begin
                  bus.mem_a_o = w_addr_k;
                  w_cnt_next  = r_cnt + 3'd1;
               end else begin
                  w_cnt_next   = 3'd0;
                  w_state_next = MEM_DONE;
               end
            end
            MEM_STORE: begin
               bus.mem_a_o     = w_addr_k;
               bus.mem_dout_o  = w_sbyte;
               bus.mem_wr_o    = 1'b1;
               bus.stall_req_o = 1'b1;
               if (r_cnt == w_size - 3'd1) begin
                  w_cnt_next   = 3'd0;
                  w_state_next = MEM_DONE;
               end else begin
                  w_cnt_next = r_cnt + 3'd1;
               end
            end
            MEM_DONE: begin
               bus.wd_o = bus.wd_i;
               if (w_is_load) begin
                  bus.wreg_o  = bus.wreg_i;
                  bus.wdata_o = w_ext;
               end else begin
                  bus.wreg_o  = 1'b0;
                  bus.wdata_o = bus.wdata_i;
               end
               w_state_next = MEM_IDLE;
            end
            default: w_state_next = MEM_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for the memory-access stage: fixed vectors, reset
// corner cases and randomized ops against a byte-array reference model.
module tb_mem;
   import mem_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_if #(.ADDR_W(32)) bus();

   mem #(.ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
   } wr_t;

   typedef struct {
      string       nm;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      int          stall;
      logic        xwreg;
      logic [31:0] xdata;
      logic        chkd;
   } vec_t;

   logic [7:0]  ram     [logic [31:0]];
   logic [7:0]  ref_mem [logic [31:0]];
   wr_t         wlog[$];
   logic [31:0] alog[$];
   vec_t        tbl[13];
   int          total = 0;
   int          bad   = 0;

   function automatic void ram_wr(input logic [31:0] a, input logic [7:0] d);
      wr_t w;
      ram[a] = d;
      w.a = a;
      w.d = d;
      wlog.push_back(w);
   endfunction

   // Byte-wide RAM: registered read, write on the rising edge.
   always @(posedge clk) begin
      bus.mem_din_i <= ram.exists(bus.mem_a_o) ? ram[bus.mem_a_o] : 8'h00;
      if (bus.mem_wr_o) ram_wr(bus.mem_a_o, bus.mem_dout_o);
   end

   function automatic void preload(input logic [31:0] a, input logic [7:0] d);
      ram[a]     = d;
      ref_mem[a] = d;
   endfunction

   function automatic logic [7:0] ref_byte(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   function automatic int sz(input logic [2:0] f3);
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   // Little-endian assembly followed by arithmetic sign extension.
   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] raw;
      raw = 32'h0;
      for (int k = 0; k < sz(f3); k++)
         raw = raw + (32'(ref_byte(a + 32'(k))) << (8 * k));
      if (f3 == 3'd0 && raw >= 32'd128)   return raw - 32'd256;
      if (f3 == 3'd1 && raw >= 32'd32768) return raw - 32'd65536;
      return raw;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata);
      bus.opcode_i = op;
      bus.func3_i  = f3;
      bus.addr_i   = addr;
      bus.sdata_i  = sdata;
      bus.wd_i     = wd;
      bus.wreg_i   = wreg;
      bus.wdata_i  = wdata;
   endtask

   task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, output int n_stall, output int n_wr,
                         output logic [31:0] o_wdata, output logic o_wreg,
                         output logic [4:0] o_wd, output logic tmo);
      @(negedge clk);
      rst = 1'b0;
      drive(op, f3, addr, sdata, wd, wreg, wdata);
      wlog.delete();
      alog.delete();
      n_stall = 0;
      n_wr    = 0;
      o_wdata = 32'h0;
      o_wreg  = 1'b0;
      o_wd    = 5'd0;
      tmo     = 1'b1;
      for (int c = 0; c < 16; c++) begin
         #1;
         if (bus.stall_req_o) begin
            n_stall++;
            if (bus.mem_wr_o) n_wr++;
            alog.push_back(bus.mem_a_o);
            @(negedge clk);
         end else begin
            o_wdata = bus.wdata_o;
            o_wreg  = bus.wreg_o;
            o_wd    = bus.wd_o;
            tmo     = 1'b0;
            break;
         end
      end
   endtask

   task automatic verify(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] wd,
                         input logic wreg, input logic [31:0] wdata, input int exp_stall,
                         input logic exp_wreg, input logic [31:0] exp_wdata, input logic chkd);
      int          n_stall, n_wr, n;
      logic [31:0] o_wdata, act, sb;
      logic        o_wreg, tmo, is_ld, is_st;
      logic [4:0]  o_wd;
      n     = sz(f3);
      is_ld = (op == OP_LOAD);
      is_st = (op == OP_STORE);
      run_op(op, f3, addr, sdata, wd, wreg, wdata, n_stall, n_wr, o_wdata, o_wreg, o_wd, tmo);
      chk({nm, "/timeout"}, {31'b0, tmo}, 32'h0);
      chk({nm, "/stall"}, 32'(n_stall), 32'(exp_stall));
      chk({nm, "/wr_cycles"}, 32'(n_wr), is_st ? 32'(n) : 32'h0);
      chk({nm, "/wreg"}, {31'b0, o_wreg}, {31'b0, exp_wreg});
      if (!is_st) chk({nm, "/wd"}, {27'b0, o_wd}, {27'b0, wd});
      if (chkd) chk({nm, "/wdata"}, o_wdata, exp_wdata);
      if (is_ld || is_st) begin
         for (int k = 0; k < n; k++) begin
            act = (k < alog.size()) ? alog[k] : 32'hDEAD_BEEF;
            chk({nm, "/addr"}, act, addr + 32'(k));
         end
      end
      if (is_st) begin
         chk({nm, "/nwrites"}, 32'(wlog.size()), 32'(n));
         for (int k = 0; k < n; k++) begin
            sb = (sdata >> (8 * k)) & 32'hFF;
            if (k < wlog.size()) begin
               chk({nm, "/waddr"}, wlog[k].a, addr + 32'(k));
               chk({nm, "/wbyte"}, {24'h0, wlog[k].d}, sb);
            end
            ref_mem[addr + 32'(k)] = sb[7:0];
         end
      end
      $display("op %s opc=%h f3=%0d addr=%h stall=%0d wreg=%0d wdata=%h", nm, op, f3, addr,
               n_stall, o_wreg, o_wdata);
   endtask

   // Assert reset in the second cycle of an access and leave it held for run_op to release.
   task automatic rst_mid(input string nm, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata);
      @(negedge clk);
      rst = 1'b0;
      drive(op, f3, addr, sdata, 5'd3, 1'b1, 32'h55);
      #1 chk({nm, "/t0_stall"}, {31'b0, bus.stall_req_o}, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk({nm, "/rst_stall"}, {31'b0, bus.stall_req_o}, 32'h0);
      chk({nm, "/rst_wr"}, {31'b0, bus.mem_wr_o}, 32'h0);
      chk({nm, "/rst_a"}, bus.mem_a_o, 32'h0);
      chk({nm, "/rst_dout"}, {24'h0, bus.mem_dout_o}, 32'h0);
      chk({nm, "/rst_wreg"}, {31'b0, bus.wreg_o}, 32'h0);
      chk({nm, "/rst_wdata"}, bus.wdata_o, 32'h0);
      chk({nm, "/rst_wd"}, {27'b0, bus.wd_o}, 32'h0);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] addr, sdata, wdata, xdata;
      logic [4:0]  wd;
      logic        wreg, ld, st;
      int          kind, xstall;

      tbl[0]  = '{"addi",    7'h13,    3'd0,       32'h0,         32'h0,         5'd5, 1'b1, 32'h1234, 0, 1'b1, 32'h1234,     1'b1};
      tbl[1]  = '{"lw100",   OP_LOAD,  FUNCT3_LW,  32'h100,       32'h0,         5'd7, 1'b1, 32'hCAFE, 5, 1'b1, 32'h12345678, 1'b1};
      tbl[2]  = '{"lb80",    OP_LOAD,  FUNCT3_LB,  32'h80,        32'h0,         5'd8, 1'b1, 32'hCAFE, 2, 1'b1, 32'hFFFFFF80, 1'b1};
      tbl[3]  = '{"lbu80",   OP_LOAD,  FUNCT3_LBU, 32'h80,        32'h0,         5'd9, 1'b1, 32'hCAFE, 2, 1'b1, 32'h00000080, 1'b1};
      tbl[4]  = '{"lh90",    OP_LOAD,  FUNCT3_LH,  32'h90,        32'h0,         5'd10, 1'b1, 32'h0,   3, 1'b1, 32'hFFFF8001, 1'b1};
      tbl[5]  = '{"lhu90",   OP_LOAD,  FUNCT3_LHU, 32'h90,        32'h0,         5'd11, 1'b1, 32'h0,   3, 1'b1, 32'h00008001, 1'b1};
      tbl[6]  = '{"sh200",   OP_STORE, FUNCT3_SH,  32'h200,       32'hAABBCCDD,  5'd12, 1'b1, 32'h0,   2, 1'b0, 32'h0,        1'b0};
      tbl[7]  = '{"lbu201",  OP_LOAD,  FUNCT3_LBU, 32'h201,       32'h0,         5'd13, 1'b1, 32'h0,   2, 1'b1, 32'h000000CC, 1'b1};
      tbl[8]  = '{"sw_wrap", OP_STORE, FUNCT3_SW,  32'hFFFFFFFE,  32'h11223344,  5'd14, 1'b1, 32'h0,   4, 1'b0, 32'h0,        1'b0};
      tbl[9]  = '{"lw_wrap", OP_LOAD,  FUNCT3_LW,  32'hFFFFFFFE,  32'h0,         5'd15, 1'b1, 32'h0,   5, 1'b1, 32'h11223344, 1'b1};
      tbl[10] = '{"sb300",   OP_STORE, FUNCT3_SB,  32'h300,       32'h0000005A,  5'd16, 1'b1, 32'h0,   1, 1'b0, 32'h0,        1'b0};
      tbl[11] = '{"lw_x0",   OP_LOAD,  FUNCT3_LW,  32'h100,       32'h0,         5'd0, 1'b1, 32'h0,    5, 1'b1, 32'h12345678, 1'b1};
      tbl[12] = '{"ld_f3bad", OP_LOAD, 3'b011,     32'h100,       32'h0,         5'd17, 1'b1, 32'h0,   5, 1'b1, 32'h12345678, 1'b1};

      preload(32'h100, 8'h78);
      preload(32'h101, 8'h56);
      preload(32'h102, 8'h34);
      preload(32'h103, 8'h12);
      preload(32'h80,  8'h80);
      preload(32'h90,  8'h01);
      preload(32'h91,  8'h80);
      for (int k = 0; k < 24; k++) preload(32'h1000 + 32'(k), 8'($urandom));
      for (int k = 0; k < 8; k++)  preload(32'hFFFFFFF8 + 32'(k), 8'($urandom));

      // Reset state, with a live pass-through op on the inputs.
      rst = 1'b1;
      drive(7'h13, 3'd0, 32'h44, 32'h99, 5'd5, 1'b1, 32'hDEAD);
      repeat (2) @(negedge clk);
      #1;
      chk("reset/stall", {31'b0, bus.stall_req_o}, 32'h0);
      chk("reset/wr", {31'b0, bus.mem_wr_o}, 32'h0);
      chk("reset/a", bus.mem_a_o, 32'h0);
      chk("reset/dout", {24'h0, bus.mem_dout_o}, 32'h0);
      chk("reset/wd", {27'b0, bus.wd_o}, 32'h0);
      chk("reset/wreg", {31'b0, bus.wreg_o}, 32'h0);
      chk("reset/wdata", bus.wdata_o, 32'h0);

      for (int i = 0; i < 13; i++)
         verify(tbl[i].nm, tbl[i].op, tbl[i].f3, tbl[i].addr, tbl[i].sdata, tbl[i].wd,
                tbl[i].wreg, tbl[i].wdata, tbl[i].stall, tbl[i].xwreg, tbl[i].xdata, tbl[i].chkd);

      // Reset mid-access; the held op must restart from byte 0.
      rst_mid("rst_lw", OP_LOAD, FUNCT3_LW, 32'h100, 32'h0);
      verify("rst_lw_again", OP_LOAD, FUNCT3_LW, 32'h100, 32'h0, 5'd3, 1'b1, 32'h55,
             5, 1'b1, 32'h12345678, 1'b1);
      rst_mid("rst_sw", OP_STORE, FUNCT3_SW, 32'h400, 32'hCAFEF00D);
      verify("rst_sw_again", OP_STORE, FUNCT3_SW, 32'h400, 32'hCAFEF00D, 5'd3, 1'b1, 32'h55,
             4, 1'b0, 32'h0, 1'b0);
      verify("rst_sw_read", OP_LOAD, FUNCT3_LW, 32'h400, 32'h0, 5'd4, 1'b1, 32'h0,
             5, 1'b1, 32'hCAFEF00D, 1'b1);

      for (int i = 0; i < 150; i++) begin
         kind = $urandom_range(0, 2);
         case ($urandom_range(0, 2))
            0:       addr = 32'h1000 + 32'($urandom_range(0, 15));
            1:       addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            default: addr = 32'($urandom_range(0, 4));
         endcase
         sdata = $urandom;
         wdata = $urandom;
         wd    = 5'($urandom);
         wreg  = 1'($urandom);
         if (kind == 0) begin
            op = OP_LOAD;
            case ($urandom_range(0, 4))
               0: f3 = FUNCT3_LB;
               1: f3 = FUNCT3_LH;
               2: f3 = FUNCT3_LW;
               3: f3 = FUNCT3_LBU;
               default: f3 = FUNCT3_LHU;
            endcase
         end else if (kind == 1) begin
            op = OP_STORE;
            f3 = 3'($urandom_range(0, 2));
         end else begin
            op = ($urandom_range(0, 1) == 0) ? 7'h13 : 7'h33;
            f3 = 3'($urandom);
         end
         ld     = (op == OP_LOAD);
         st     = (op == OP_STORE);
         xstall = ld ? sz(f3) + 1 : (st ? sz(f3) : 0);
         xdata  = ld ? model_load(f3, addr) : wdata;
         verify($sformatf("rnd%0d", i), op, f3, addr, sdata, wd, wreg, wdata,
                xstall, st ? 1'b0 : wreg, xdata, !st);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
